// File: rtl/gpioemu_pkg.sv
// Shared definitions for the gpioemu register map, host sequencing and bus phases.
package gpioemu_pkg;

  localparam logic [15:0] ADDR_A1   = 16'h037F;
  localparam logic [15:0] ADDR_A2   = 16'h0388;
  localparam logic [15:0] ADDR_CTRL = 16'h03A0;
  localparam logic [15:0] ADDR_W    = 16'h0390;
  localparam logic [15:0] ADDR_L    = 16'h0398;

  localparam logic [1:0]  STATUS_DONE = 2'b11;
  localparam logic [31:0] CTRL_START  = 32'h0000_0001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_A1,
    S_WR_A2,
    S_WR_CTRL,
    S_POLL,
    S_RD_W,
    S_RD_L,
    S_RESP
  } host_state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_STROBE,
    PH_HOLD
  } bus_phase_t;

  function automatic logic [31:0] zext24(input logic [23:0] v);
    return {8'h00, v};
  endfunction

endpackage

// File: rtl/gpioemu_host_if.sv
// Command/response handshake plus the gpioemu register bus, seen from the host side.
interface gpioemu_host_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [23:0] cmd_a1;
  logic [23:0] cmd_a2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_w;
  logic [5:0]  rsp_ones;
  logic        rsp_timeout;
  logic [15:0] saddress;
  logic        srd;
  logic        swr;
  logic [31:0] sdata_out;
  logic [31:0] sdata_in;

  modport master (
    input  cmd_valid, cmd_a1, cmd_a2, rsp_ready, sdata_in,
    output cmd_ready, rsp_valid, rsp_w, rsp_ones, rsp_timeout,
           saddress, srd, swr, sdata_out
  );

  modport slave (
    output cmd_valid, cmd_a1, cmd_a2, rsp_ready, sdata_in,
    input  cmd_ready, rsp_valid, rsp_w, rsp_ones, rsp_timeout,
           saddress, srd, swr, sdata_out
  );
endinterface

// File: rtl/gpioemu_bus_access.sv
// One register access: SETUP, STROBE_CYCLES of strobe, HOLD. A new access may be
// launched during HOLD so consecutive accesses run without an idle gap.
module gpioemu_bus_access
  import gpioemu_pkg::*;
#(
  parameter int STROBE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        start,
  input  logic        rnw,
  input  logic [15:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic [15:0] saddress,
  output logic        srd,
  output logic        swr,
  output logic [31:0] sdata_out,
  input  logic [31:0] sdata_in
);

  localparam int STB_W = $clog2(STROBE_CYCLES + 1);

  bus_phase_t       phase_reg;
  logic [STB_W-1:0] stb_cnt_reg;
  logic             rnw_reg;
  logic [15:0]      saddress_reg;
  logic [31:0]      sdata_out_reg;
  logic             srd_reg;
  logic             swr_reg;
  logic             launch;

  assign launch = start && (phase_reg == PH_IDLE || phase_reg == PH_HOLD);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      phase_reg     <= PH_IDLE;
      stb_cnt_reg   <= '0;
      rnw_reg       <= 1'b0;
      saddress_reg  <= '0;
      sdata_out_reg <= '0;
      srd_reg       <= 1'b0;
      swr_reg       <= 1'b0;
    end else begin
      case (phase_reg)
        PH_SETUP: begin
          phase_reg   <= PH_STROBE;
          srd_reg     <= rnw_reg;
          swr_reg     <= !rnw_reg;
          stb_cnt_reg <= STB_W'(1);
        end
        PH_STROBE: begin
          if (stb_cnt_reg == STB_W'(STROBE_CYCLES)) begin
            phase_reg <= PH_HOLD;
            srd_reg   <= 1'b0;
            swr_reg   <= 1'b0;
          end else begin
            stb_cnt_reg <= stb_cnt_reg + 1'b1;
          end
        end
        PH_HOLD: begin
          phase_reg     <= PH_IDLE;
          sdata_out_reg <= '0;
        end
        default: ;
      endcase
      // A launch overrides the HOLD->IDLE exit above.
      if (launch) begin
        phase_reg     <= PH_SETUP;
        rnw_reg       <= rnw;
        saddress_reg  <= addr;
        sdata_out_reg <= rnw ? 32'h0 : wdata;
      end
    end
  end

  assign busy      = (phase_reg != PH_IDLE);
  assign done      = (phase_reg == PH_HOLD);
  assign rdata     = sdata_in;
  assign saddress  = saddress_reg;
  assign srd       = srd_reg;
  assign swr       = swr_reg;
  assign sdata_out = sdata_out_reg;

endmodule

// File: rtl/gpioemu_host.sv
// Bus initiator that runs a full gpioemu multiply: write operands, start, poll
// status, read product and ones count, and return them on the response port.
module gpioemu_host
  import gpioemu_pkg::*;
#(
  parameter int STROBE_CYCLES = 2,
  parameter int POLL_LIMIT    = 1024
) (
  input logic            clk,
  input logic            n_reset,
  gpioemu_host_if.master bus
);

  localparam int CNT_W = $clog2(POLL_LIMIT + 1);

  host_state_t      state_reg;
  logic [23:0]      a2_reg;
  logic [CNT_W-1:0] poll_cnt_reg;
  logic             cmd_ready_reg;
  logic             rsp_valid_reg;
  logic             rsp_timeout_reg;
  logic [31:0]      rsp_w_reg;
  logic [5:0]       rsp_ones_reg;

  logic        acc_start;
  logic        acc_rnw;
  logic [15:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        acc_busy;
  logic        acc_done;
  logic [31:0] acc_rdata;
  logic        status_done;
  logic        poll_last;

  assign status_done = (acc_rdata[1:0] == STATUS_DONE);
  assign poll_last   = (poll_cnt_reg == CNT_W'(POLL_LIMIT - 1));

  // The next access is launched on the same edge that moves the FSM into the
  // state owning it, so accesses chain back to back.
  always_comb begin
    acc_start = 1'b0;
    acc_rnw   = 1'b1;
    acc_addr  = ADDR_CTRL;
    acc_wdata = 32'h0;
    case (state_reg)
      S_IDLE: begin
        if (bus.cmd_valid && cmd_ready_reg && !acc_busy) begin
          acc_start = 1'b1;
          acc_rnw   = 1'b0;
          acc_addr  = ADDR_A1;
          acc_wdata = zext24(bus.cmd_a1);
        end
      end
      S_WR_A1: begin
        if (acc_done) begin
          acc_start = 1'b1;
          acc_rnw   = 1'b0;
          acc_addr  = ADDR_A2;
          acc_wdata = zext24(a2_reg);
        end
      end
      S_WR_A2: begin
        if (acc_done) begin
          acc_start = 1'b1;
          acc_rnw   = 1'b0;
          acc_wdata = CTRL_START;
        end
      end
      S_WR_CTRL: acc_start = acc_done;
      S_POLL: begin
        if (acc_done) begin
          if (status_done) begin
            acc_start = 1'b1;
            acc_addr  = ADDR_W;
          end else begin
            acc_start = !poll_last;
          end
        end
      end
      S_RD_W: begin
        if (acc_done) begin
          acc_start = 1'b1;
          acc_addr  = ADDR_L;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_reg       <= S_IDLE;
      a2_reg          <= '0;
      poll_cnt_reg    <= '0;
      cmd_ready_reg   <= 1'b1;
      rsp_valid_reg   <= 1'b0;
      rsp_timeout_reg <= 1'b0;
      rsp_w_reg       <= '0;
      rsp_ones_reg    <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (acc_start) begin
            a2_reg          <= bus.cmd_a2;
            poll_cnt_reg    <= '0;
            cmd_ready_reg   <= 1'b0;
            rsp_timeout_reg <= 1'b0;
            rsp_w_reg       <= '0;
            rsp_ones_reg    <= '0;
            state_reg       <= S_WR_A1;
          end
        end
        S_WR_A1:   if (acc_done) state_reg <= S_WR_A2;
        S_WR_A2:   if (acc_done) state_reg <= S_WR_CTRL;
        S_WR_CTRL: if (acc_done) state_reg <= S_POLL;
        S_POLL: begin
          if (acc_done) begin
            poll_cnt_reg <= poll_cnt_reg + 1'b1;
            if (status_done) begin
              state_reg <= S_RD_W;
            end else if (poll_last) begin
              rsp_timeout_reg <= 1'b1;
              rsp_valid_reg   <= 1'b1;
              state_reg       <= S_RESP;
            end
          end
        end
        S_RD_W: begin
          if (acc_done) begin
            rsp_w_reg <= acc_rdata;
            state_reg <= S_RD_L;
          end
        end
        S_RD_L: begin
          if (acc_done) begin
            rsp_ones_reg  <= acc_rdata[5:0];
            rsp_valid_reg <= 1'b1;
            state_reg     <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            cmd_ready_reg <= 1'b1;
            state_reg     <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  gpioemu_bus_access #(
    .STROBE_CYCLES(STROBE_CYCLES)
  ) u_access (
    .clk      (clk),
    .n_reset  (n_reset),
    .start    (acc_start),
    .rnw      (acc_rnw),
    .addr     (acc_addr),
    .wdata    (acc_wdata),
    .busy     (acc_busy),
    .done     (acc_done),
    .rdata    (acc_rdata),
    .saddress (bus.saddress),
    .srd      (bus.srd),
    .swr      (bus.swr),
    .sdata_out(bus.sdata_out),
    .sdata_in (bus.sdata_in)
  );

  assign bus.cmd_ready   = cmd_ready_reg;
  assign bus.rsp_valid   = rsp_valid_reg;
  assign bus.rsp_timeout = rsp_timeout_reg;
  assign bus.rsp_w       = rsp_w_reg;
  assign bus.rsp_ones    = rsp_ones_reg;

endmodule

// File: doc/gpioemu_host.md
# gpioemu_host

Bus initiator that drives the gpioemu register interface from the other end. It takes a 24×24 multiply request on a valid/ready command port and writes both operands and the start command as bus write strobes. It then polls the status register until the peripheral reports done, reads back the 32-bit product and the ones count, and presents them on a valid/ready response port. It sits between on-chip control logic and the emulated peripheral, replacing software-driven register access in system testbenches and FPGA builds.

## Interface
- ADDR_A1, 16'h037F, operand A1 register address
- ADDR_A2, 16'h0388, operand A2 register address
- ADDR_CTRL, 16'h03A0, start (write) / status (read) register address
- ADDR_W, 16'h0390, product low-word register address
- ADDR_L, 16'h0398, ones-count register address
- STROBE_CYCLES, 2, cycles srd/swr held high per access (≥1)
- POLL_LIMIT, 1024, maximum status reads before timeout (≥1)

- clk  in  1  clock
- n_reset  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  request present
- cmd_ready  out  1  block idle, request accepted when both high
- cmd_a1  in  24  operand A1
- cmd_a2  in  24  operand A2
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when both high
- rsp_w  out  32  product bits [31:0]
- rsp_ones  out  6  ones count (0..32)
- rsp_timeout  out  1  poll limit exceeded; rsp_w/rsp_ones = 0
- saddress  out  16  bus address
- srd  out  1  read strobe
- swr  out  1  write strobe
- sdata_out  out  32  write data to peripheral
- sdata_in  in  32  read data from peripheral

## Operation
- Reset values: cmd_ready=1; all other outputs 0. srd/swr drop immediately on n_reset assertion.
- States: IDLE → WR_A1 → WR_A2 → WR_CTRL → POLL → RD_W → RD_L → RESP → IDLE.
- IDLE: cmd_ready=1. On handshake, latch cmd_a1/cmd_a2 and clear the poll counter.
- WR_A1: write {8'h0,a1} to ADDR_A1. WR_A2: write {8'h0,a2} to ADDR_A2. WR_CTRL: write 32'h1 to ADDR_CTRL.
- POLL: read ADDR_CTRL and increment the poll counter.
  - sdata_in[1:0]==2'b11 → RD_W.
  - Otherwise, poll counter == POLL_LIMIT → RESP with rsp_timeout=1.
  - Otherwise, repeat POLL.
- RD_W: read ADDR_W into rsp_w. RD_L: read ADDR_L; rsp_ones=sdata_in[5:0] (upper bits ignored).
- RESP: rsp_valid=1 with data stable until rsp_ready; then IDLE. cmd_ready=0 in every state except IDLE.
- Bus access, performed by the sub-sequencer, runs three phases:
  - SETUP: 1 cycle. saddress and sdata_out driven, strobes low.
  - STROBE: STROBE_CYCLES cycles. srd or swr high.
  - HOLD: 1 cycle. Strobes low, saddress and sdata_out still held; reads sample sdata_in at the end of this cycle.
- Between accesses saddress holds its last value; sdata_out is 0 except during write accesses.
- srd and swr are never high together. A strobe is never asserted while saddress changes.

## Timing
- One access = STROBE_CYCLES+2 cycles (4 at default). Back-to-back accesses have no idle gap.
- Accepted command with done on first poll: 6 accesses. At default, rsp_valid rises in cycle 25 after the handshake cycle.
- Each extra poll adds STROBE_CYCLES+2 cycles.
- Timeout response after at most 3+POLL_LIMIT accesses.
- RESP→IDLE transition on the cycle of the rsp handshake; cmd_ready=1 the following cycle.
- cmd_valid while busy: ignored, no state change.
- n_reset mid-operation: abort at once, with no completion of the bus access; return to reset values. The peripheral is not re-reset by this block.

## Structure
- Shared package gpioemu_pkg: register address constants (also used by gpioemu), host state enum, bus-phase enum, status done value 2'b11.
- One sub-module gpioemu_bus_access: single read/write access sequencer. Inputs are start, rnw, addr, wdata; outputs are busy, done pulse, rdata, and the bus pins. The top-level FSM issues one access per state visit.

## Test plan
- a1=3, a2=5 against a behavioural peripheral model: writes 0x37F=3, 0x388=5, 0x3A0=1. Poll returns 11 on the 2nd read. Response rsp_w=15, rsp_ones=4, rsp_timeout=0.
- a1=a2=24'hFFFFFF: rsp_w=32'hFE000001, rsp_ones=8.
- Model holds status at 2'b01 forever: exactly POLL_LIMIT reads of 0x3A0, then rsp_timeout=1, rsp_w=0, rsp_ones=0.
- rsp_ready low for 10 cycles after rsp_valid: rsp_* held stable, cmd_ready=0, no bus activity. cmd_ready=1 one cycle after the handshake.
- n_reset asserted during a POLL strobe: srd=0 asynchronously, all outputs at reset values. After release, a new command a1=2, a2=7 completes with rsp_w=14.
- Bus monitor across 50 random commands:
  - srd&swr never both high.
  - saddress stable from SETUP through HOLD.
  - Every strobe pulse exactly STROBE_CYCLES cycles long.
